// File: rtl/skid_pipeline.sv
// skid_pipeline: chain of registered-ready skid stages with flush and occupancy count
module skid_pipeline #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES = 2,
  localparam int OCC_W = $clog2(2*STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occupancy
);
  logic [STAGES-1:0] mv, sv, acc, drn;
  logic [STAGES:0] vin, rdy;
  logic [DATA_WIDTH-1:0] md [STAGES];
  logic [DATA_WIDTH-1:0] sd [STAGES];
  logic [DATA_WIDTH-1:0] din [STAGES+1];
  logic rdy_en;
  assign in_ready = rdy_en & !sv[0] & !flush;
  assign out_valid = mv[STAGES-1] & !flush;
  assign out_data = md[STAGES-1];
  // stage k accepts from stage k-1 (or upstream) and drains into stage k+1 (or downstream)
  always_comb begin
    vin = {mv, in_valid};
    rdy = {out_ready & !flush, ~sv};
    rdy[0] = in_ready;
    acc = vin[STAGES-1:0] & rdy[STAGES-1:0];
    drn = mv & rdy[STAGES:1];
    din[0] = in_data;
    for (int k = 0; k < STAGES; k++) din[k+1] = md[k];
  end
  // occupancy is the number of held words across all main and skid registers
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + OCC_W'(mv[k]) + OCC_W'(sv[k]);
  end
  // per-stage EMPTY/BUSY/FULL transitions; data registers load only on acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en <= 1'b0;
      mv <= '0;
      sv <= '0;
      for (int k = 0; k < STAGES; k++) begin
        md[k] <= '0;
        sd[k] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      mv <= {STAGES{!flush}} & (sv | acc | (mv & ~drn));
      sv <= {STAGES{!flush}} & ~drn & (sv | (mv & acc));
      for (int k = 0; k < STAGES; k++) begin
        if (sv[k] & drn[k]) md[k] <= sd[k];
        else if (acc[k] & (!mv[k] | drn[k])) md[k] <= din[k];
        if (acc[k] & mv[k] & !drn[k]) sd[k] <= din[k];
      end
    end
endmodule
